// File: rtl/carry_bcd_scan_display_if.sv
// Pin bundle between the mod-8 counter stage, the carry/BCD scan display and the board.
// The master side drives the counter outputs and observes the display pins.
// The slave side is the display block.
interface carry_bcd_scan_display_if;
    logic [3:0] q_in;
    logic       qcc_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       ovf;

    modport master (
        output q_in,
        output qcc_in,
        input  seg,
        input  an,
        input  dp,
        input  ovf
    );

    modport slave (
        input  q_in,
        input  qcc_in,
        output seg,
        output an,
        output dp,
        output ovf
    );
endinterface

// File: rtl/carry_bcd_scan_display.sv
// carry_bcd_scan_display
//
// Samples the mod-8 counter's Q and carry. Counts carry rising edges in a
// 3-digit BCD counter (000-999, with an ovf pulse on wrap). Scans four
// active-low 7-segment digits: digit0 = live Q, digits 1-3 = carry count
// units/tens/hundreds.
//
// Optional build macro BLANK_LEADING_ZERO_EN blanks leading zeros on the
// hundreds and tens digits. When it is undefined, every digit shows its value.
module carry_bcd_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input logic                   cp,
    input logic                   clr_n,
    carry_bcd_scan_display_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    logic [3:0]       r_q;
    logic             r_qcc;
    logic             r_qcc_d;
    logic [3:0]       r_d1;
    logic [3:0]       r_d2;
    logic [3:0]       r_d3;
    logic             r_ovf;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_sel;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_carry_pulse;
    logic             w_div_last;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [6:0]       w_seg;
    logic [3:0]       w_an;
    logic             w_dp;

    // Full 0-F hex decode, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Input stage: register Q and carry, plus a delayed carry for edge detection.
    always_ff @(posedge cp or negedge clr_n) begin
        if (!clr_n) begin
            r_q     <= 4'd0;
            r_qcc   <= 1'b0;
            r_qcc_d <= 1'b0;
        end else begin
            r_q     <= bus.q_in;
            r_qcc   <= bus.qcc_in;
            r_qcc_d <= r_qcc;
        end
    end

    // A carry level that stays high for many cycles still counts only once.
    assign w_carry_pulse = r_qcc & ~r_qcc_d;

    // BCD carry counter with ripple between digits. ovf marks the 999->000 wrap.
    always_ff @(posedge cp or negedge clr_n) begin
        if (!clr_n) begin
            r_d1  <= 4'd0;
            r_d2  <= 4'd0;
            r_d3  <= 4'd0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_carry_pulse) begin
                if (r_d1 == 4'd9) begin
                    r_d1 <= 4'd0;
                    if (r_d2 == 4'd9) begin
                        r_d2 <= 4'd0;
                        if (r_d3 == 4'd9) begin
                            r_d3  <= 4'd0;
                            r_ovf <= 1'b1;
                        end else begin
                            r_d3 <= r_d3 + 4'd1;
                        end
                    end else begin
                        r_d2 <= r_d2 + 4'd1;
                    end
                end else begin
                    r_d1 <= r_d1 + 4'd1;
                end
            end
        end
    end

    assign w_div_last = (r_div == DIV_LAST);
    assign w_sel_nxt  = w_div_last ? (r_sel + 2'd1) : r_sel;

    // Scan divider: each digit stays selected for SCAN_DIV cycles.
    always_ff @(posedge cp or negedge clr_n) begin
        if (!clr_n) begin
            r_div <= '0;
            r_sel <= 2'd0;
        end else begin
            r_div <= w_div_last ? '0 : (r_div + DIV_W'(1));
            r_sel <= w_sel_nxt;
        end
    end

    // Pick the digit for the upcoming select, and decide whether it is blanked.
    always_comb begin
        w_nibble = r_q;
        case (w_sel_nxt)
            2'd0:    w_nibble = r_q;
            2'd1:    w_nibble = r_d1;
            2'd2:    w_nibble = r_d2;
            default: w_nibble = r_d3;
        endcase

`ifdef BLANK_LEADING_ZERO_EN
        w_blank = ((w_sel_nxt == 2'd3) && (r_d3 == 4'd0)) ||
                  ((w_sel_nxt == 2'd2) && (r_d3 == 4'd0) && (r_d2 == 4'd0));
`else
        w_blank = 1'b0;
`endif

        w_seg = w_blank ? SEG_BLANK : hex_to_seg(w_nibble);
        w_an  = ~(4'b0001 << w_sel_nxt);
        w_dp  = (w_sel_nxt != 2'd0);
    end

    // Register the pins so a digit and its anode always change together.
    always_ff @(posedge cp or negedge clr_n) begin
        if (!clr_n) begin
            r_an  <= 4'b1110;
            r_seg <= 7'b1000000;
            r_dp  <= 1'b0;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_carry_bcd_scan_display.sv
// Directed bench for carry_bcd_scan_display with SCAN_DIV=4, DIV_W=2.
module tb_carry_bcd_scan_display;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [6:0] LEAD_ZERO = 7'b1111111;
`else
    localparam logic [6:0] LEAD_ZERO = 7'b1000000;
`endif

    logic cp    = 1'b0;
    logic clr_n = 1'b1;

    carry_bcd_scan_display_if bus ();

    carry_bcd_scan_display #(.SCAN_DIV(4), .DIV_W(2)) dut (
        .cp    (cp),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 cp = ~cp;

    int n_vec     = 0;
    int n_bad     = 0;
    int ovf_cnt   = 0;
    int ovf_pulse = -1;
    int cur_pulse = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
        if (bus.ovf === 1'b1) begin
            ovf_cnt++;
            ovf_pulse = cur_pulse;
        end
    endtask

    task automatic wait_an_enter(input logic [3:0] target);
        logic [3:0] prev;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev = bus.an;
            tick();
            if (bus.an == target && prev != target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("scan_reached", 32'(ok), 32'd1);
    endtask

    task automatic read_digit(input int k, input string tag, input logic [6:0] exp);
        wait_an_enter(~(4'b0001 << k));
        chk(tag, 32'(bus.seg), 32'(exp));
    endtask

    task automatic pulse();
        bus.qcc_in = 1'b1;
        tick();
        bus.qcc_in = 1'b0;
        for (int i = 0; i < 7; i++) tick();
    endtask

    initial begin
        logic [3:0] exp_an;
        bus.q_in   = 4'd0;
        bus.qcc_in = 1'b0;

        #2 clr_n = 1'b0;
        #1;
        chk("rst_an",  32'(bus.an),  32'(4'b1110));
        chk("rst_seg", 32'(bus.seg), 32'(7'b1000000));
        chk("rst_dp",  32'(bus.dp),  32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        tick();
        tick();
        clr_n = 1'b1;

        // scan order and dwell, dp marks digit0 only
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_an", 32'(bus.an), 32'(exp_an));
            chk("scan_dp", 32'(bus.dp), 32'(exp_an != 4'b1110));
        end

        // live Q decode and 2-edge latency, all 16 codes
        for (int v = 0; v < 16; v++) begin
            wait_an_enter(4'b1110);
            bus.q_in = 4'(v);
            tick();
            if (v > 0) chk("q_lat_old", 32'(bus.seg), 32'(SEG_TAB[v-1]));
            tick();
            chk("q_seg", 32'(bus.seg), 32'(SEG_TAB[v]));
        end

        // 12 carries -> 012
        ovf_cnt = 0;
        for (int p = 0; p < 12; p++) pulse();
        read_digit(1, "c12_d1", SEG_TAB[2]);
        read_digit(2, "c12_d2", SEG_TAB[1]);
        read_digit(3, "c12_d3", LEAD_ZERO);

        // long carry level counts once -> 013
        bus.qcc_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.qcc_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        read_digit(1, "hold_d1", SEG_TAB[3]);
        read_digit(2, "hold_d2", SEG_TAB[1]);

        // up to 123
        for (int p = 0; p < 110; p++) pulse();
        read_digit(1, "c123_d1", SEG_TAB[3]);
        read_digit(2, "c123_d2", SEG_TAB[2]);
        read_digit(3, "c123_d3", SEG_TAB[1]);
        chk("no_ovf_yet", 32'(ovf_cnt), 32'd0);

        // asynchronous reset mid-scan
        wait_an_enter(4'b1011);
        tick();
        clr_n = 1'b0;
        #1;
        chk("mid_rst_an",  32'(bus.an),  32'(4'b1110));
        chk("mid_rst_seg", 32'(bus.seg), 32'(7'b1000000));
        chk("mid_rst_dp",  32'(bus.dp),  32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        tick();
        tick();
        clr_n = 1'b1;
        read_digit(1, "rel_d1", SEG_TAB[0]);
        read_digit(2, "rel_d2", LEAD_ZERO);
        read_digit(3, "rel_d3", LEAD_ZERO);
        read_digit(0, "rel_d0", SEG_TAB[15]);
        pulse();
        read_digit(1, "rel1_d1", SEG_TAB[1]);

        // 1000 carries from 000: 999 then wrap with one ovf cycle
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        ovf_cnt = 0;
        for (int p = 1; p <= 999; p++) begin
            cur_pulse = p;
            pulse();
        end
        read_digit(1, "c999_d1", SEG_TAB[9]);
        read_digit(2, "c999_d2", SEG_TAB[9]);
        read_digit(3, "c999_d3", SEG_TAB[9]);
        chk("ovf_before_wrap", 32'(ovf_cnt), 32'd0);
        cur_pulse = 1000;
        pulse();
        cur_pulse = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("ovf_cycles", 32'(ovf_cnt), 32'd1);
        chk("ovf_at", 32'(ovf_pulse), 32'd1000);
        read_digit(1, "wrap_d1", SEG_TAB[0]);
        read_digit(2, "wrap_d2", LEAD_ZERO);
        read_digit(3, "wrap_d3", LEAD_ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
